pipeline_controller: RTL

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/antares_pkg.sv | 37 +++
 rtl/pipeline_controller_hazard_detect.sv | 18 +
 rtl/pipeline_controller.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/antares_pkg.sv
// antares_pkg -- shared definitions for the Antares pipeline control logic.
//   * FSM state encoding of pipeline_controller (RUN=0, MEM_WAIT=1, MULDIV=2)
//   * default parameter values for pipeline_controller
//   * ctrl_t: bundle of the eight pipeline register controls
//   * ctrlRun(): the "advance normally" control setting
package antares_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MULDIV   = 2'd2;

  localparam int MULDIV_CYCLES_DEF = 32;
  localparam int MEM_TIMEOUT_DEF   = 255;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic exmemWrite;
    logic ifidFlush;
    logic idexFlush;
    logic exmemBubble;
    logic memwbBubble;
  } ctrl_t;

  // All stages advance, nothing is flushed or bubbled.
  function automatic ctrl_t ctrlRun();
    ctrl_t c;
    c             = '0;
    c.pcWrite     = 1'b1;
    c.ifidWrite   = 1'b1;
    c.idexWrite   = 1'b1;
    c.exmemWrite  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// hazard_detect -- purely combinational load-use comparator.
// Ports:
//   memReadEX  in  1  instruction in EX is a load
//   rtEX       in  5  destination register of that load
//   rsID, rtID in  5  source registers of the instruction in ID
//   loadUse    out 1  ID consumes the value the EX load has not yet produced
// Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
module hazard_detect (
  input  logic       memReadEX,
  input  logic [4:0] rtEX,
  input  logic [4:0] rsID,
  input  logic [4:0] rtID,
  output logic       loadUse
);

  assign loadUse = memReadEX && (rtEX != 5'd0) && ((rtEX == rsID) || (rtEX == rtID));

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller -- stall/flush controller of the five-stage pipeline.
// Optional feature: define ANTARES_MULDIV_EN to build the MULDIV state and its
// cycle counter; without it muldivStartEX is ignored and muldivBusy is 0.
// Parameters:
//   MULDIV_CYCLES  EX stall cycles of one multiply/divide
//   MEM_TIMEOUT    memory wait cycles after which memTimeout is raised
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rsID, rtID, rtEX, memReadEX      load-use hazard inputs
//   branchTakenID                    branch/jump taken in ID
//   memReqMEM, memReady              MEM stage access and its completion
//   muldivStartEX                    multiply/divide entering EX
//   pcWrite..exmemWrite              pipeline register enables
//   ifidFlush..memwbBubble           NOP injection into pipeline registers
//   muldivBusy                       FSM is in MULDIV
//   memTimeout                       sticky memory timeout error
//   dbgState                         current FSM state (antares_pkg encoding)
// All control outputs are Mealy: decoded from the state and the current inputs.
// There are no valid/ready handshakes here; every input is a level sampled
// each cycle.
module pipeline_controller
  import antares_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF,
  parameter int MEM_TIMEOUT   = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsID,
  input  logic [4:0] rtID,
  input  logic [4:0] rtEX,
  input  logic       memReadEX,
  input  logic       branchTakenID,
  input  logic       memReqMEM,
  input  logic       memReady,
  input  logic       muldivStartEX,
  output logic       pcWrite,
  output logic       ifidWrite,
  output logic       idexWrite,
  output logic       exmemWrite,
  output logic       ifidFlush,
  output logic       idexFlush,
  output logic       exmemBubble,
  output logic       memwbBubble,
  output logic       muldivBusy,
  output logic       memTimeout,
  output logic [1:0] dbgState
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam int MD_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  logic [1:0]      state;
  logic [1:0]      nextState;
  logic [WC_W-1:0] waitCnt;
  logic            loadUse;
  logic            luStall;
  logic            luBubbled;
  logic            memStall;
  ctrl_t           ctrl;

  hazard_detect u_hazard (
    .memReadEX (memReadEX),
    .rtEX      (rtEX),
    .rsID      (rsID),
    .rtID      (rtID),
    .loadUse   (loadUse)
  );

  assign memStall = memReqMEM && !memReady;

  // luBubbled masks the hazard for one cycle after a bubble so a single
  // load-use occurrence never produces a second bubble.
  assign luStall  = (state == RUN) && !memStall && loadUse && !luBubbled;

`ifdef ANTARES_MULDIV_EN
  logic [MD_W-1:0] mdCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCnt <= '0;
    end else if (state == RUN && !memStall && muldivStartEX) begin
      mdCnt <= MD_W'(MULDIV_CYCLES - 1);
    end else if (state == MULDIV && !memStall && mdCnt != '0) begin
      mdCnt <= mdCnt - 1'b1;
    end
  end

  assign muldivBusy = (state == MULDIV);
`else
  wire             unusedMuldivStart = muldivStartEX;
  wire [MD_W-1:0]  unusedMdInit      = MD_W'(MULDIV_CYCLES - 1);
  assign muldivBusy = 1'b0;
`endif

  // Control decode; the memory stall overrides every other rule.
  always_comb begin
    ctrl = ctrlRun();
    if (memStall) begin
      ctrl             = '0;
      ctrl.memwbBubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (luStall) begin
            ctrl.pcWrite   = 1'b0;
            ctrl.ifidWrite = 1'b0;
            ctrl.idexFlush = 1'b1;
          end else if (branchTakenID) begin
            ctrl.ifidFlush = 1'b1;
          end
        end
`ifdef ANTARES_MULDIV_EN
        MULDIV: begin
          // EX/MEM receives bubbles for the whole operation; the front of the
          // pipe is released in the final (count 0) cycle.
          ctrl.exmemBubble = 1'b1;
          if (mdCnt != '0) begin
            ctrl.pcWrite   = 1'b0;
            ctrl.ifidWrite = 1'b0;
            ctrl.idexWrite = 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
    if (!rst_n) begin
      ctrl = '0;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN: begin
        if (memStall) begin
          nextState = MEM_WAIT;
`ifdef ANTARES_MULDIV_EN
        end else if (muldivStartEX) begin
          nextState = MULDIV;
`endif
        end
      end
      MEM_WAIT: begin
        if (!memStall) begin
          nextState = RUN;
        end
      end
`ifdef ANTARES_MULDIV_EN
      MULDIV: begin
        if (!memStall && mdCnt == '0) begin
          nextState = RUN;
        end
      end
`endif
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      luBubbled <= 1'b0;
    end else begin
      state     <= nextState;
      luBubbled <= luStall;
    end
  end

  // Counts consecutive stalled cycles; saturates so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else if (memStall) begin
      if (waitCnt != WC_W'(MEM_TIMEOUT)) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (waitCnt == WC_W'(MEM_TIMEOUT - 1)) begin
        memTimeout <= 1'b1;
      end
    end else begin
      waitCnt <= '0;
    end
  end

  assign pcWrite     = ctrl.pcWrite;
  assign ifidWrite   = ctrl.ifidWrite;
  assign idexWrite   = ctrl.idexWrite;
  assign exmemWrite  = ctrl.exmemWrite;
  assign ifidFlush   = ctrl.ifidFlush;
  assign idexFlush   = ctrl.idexFlush;
  assign exmemBubble = ctrl.exmemBubble;
  assign memwbBubble = ctrl.memwbBubble;
  assign dbgState    = state;

endmodule
